pc_fetch_sequencer: RTL and testbench

Sequences instruction fetch for the RV32 subset core. Owns the architectural program counter, drives a req/ack instruction-memory port, hands each fetched word to the decoder over a valid/ready port, and applies branch/jump redirects from execute. Non-pipelined: at most one fetch is outstanding and at most one instruction is held at a time.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_fetch_sequencer_if.sv | 41 ++++
 rtl/pc_target_adder.sv | 20 ++
 rtl/pc_fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t    : sequencer FSM states
//   PC_STEP          : byte increment between sequential instructions
//   INST_W           : instruction word width
//   RESET_PC_DEFAULT : default reset PC
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int          PC_STEP          = 4;
  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the fetch sequencer's instruction-memory port, decoder port,
// redirect port and status into one interface.
//   master : the fetch sequencer side
//   slave  : memory / decoder / execute side (the testbench)
interface pc_fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  import pc_pkg::*;

  // instruction memory port
  logic              imem_req;
  logic [WIDTH-1:0]  imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  // decoder port
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [WIDTH-1:0]  inst_pc;
  logic              inst_ready;
  // redirect from execute
  logic              br_valid;
  logic              br_taken;
  logic [WIDTH-1:0]  br_pc;
  logic [WIDTH-1:0]  br_offset;
  // control / status
  logic              halt;
  logic              misalign;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
    input  imem_ack, imem_rdata, inst_ready,
           br_valid, br_taken, br_pc, br_offset, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
    output imem_ack, imem_rdata, inst_ready,
           br_valid, br_taken, br_pc, br_offset, halt
  );

endinterface

// File: rtl/pc_target_adder.sv
// Redirect target computation: taken ? base+offset : base+PC_STEP.
// Purely combinational; sums wrap modulo 2^WIDTH.
//   taken  : select branch offset (1) or fall-through (0)
//   base   : PC of the redirecting instruction
//   offset : signed immediate (two's complement add handles sign)
//   sum    : resulting target
module pc_target_adder
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             taken,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] sum
);

  assign sum = taken ? (base + offset) : (base + WIDTH'(PC_STEP));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Non-pipelined instruction fetch sequencer. Owns the PC, issues one
// req/ack fetch at a time, holds one instruction for the decoder and
// applies execute redirects (immediately, or deferred until the
// outstanding fetch acks).
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_fetch_sequencer_if.master (imem, decoder, redirect, halt,
//          misalign)
// Build option PCFETCH_MISALIGN_TRAP_EN: a redirect target with
// bits[1:0]!=0 sets sticky misalign and halts. Without it, target low
// bits are cleared and misalign stays 0.
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_sequencer_if.master  bus
);

`ifdef PCFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t      state;
  logic [WIDTH-1:0]  pc;
  logic              pend;
  logic [WIDTH-1:0]  pend_tgt;
  logic              req_q;
  logic [WIDTH-1:0]  addr_q;
  logic              ivld_q;
  logic [INST_W-1:0] inst_q;
  logic [WIDTH-1:0]  ipc_q;
  logic              mis_q;

  logic [WIDTH-1:0]  tgt_raw;
  logic [WIDTH-1:0]  tgt;
  logic [WIDTH-1:0]  redir;
  logic [WIDTH-1:0]  pc_inc;
  logic              tgt_mis;
  logic              trap;

  pc_target_adder #(.WIDTH(WIDTH)) u_tgt (
    .taken  (bus.br_taken),
    .base   (bus.br_pc),
    .offset (bus.br_offset),
    .sum    (tgt_raw)
  );

  // Aligned targets are the only ones ever loaded: with the trap on a
  // misaligned target halts instead, so masking is harmless there.
  assign tgt_mis = |tgt_raw[1:0];
  assign tgt     = {tgt_raw[WIDTH-1:2], 2'b00};
  assign trap    = TRAP_EN && bus.br_valid && tgt_mis;
  // A redirect arriving with the ack is newer than any pending one.
  assign redir   = bus.br_valid ? tgt : pend_tgt;
  assign pc_inc  = pc + WIDTH'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      ivld_q   <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= REQ;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        REQ: begin
          if (trap) begin
            mis_q <= 1'b1;
            pend  <= 1'b0;
            req_q <= 1'b0;
            state <= HALTED;
          end else if (bus.imem_ack) begin
            if (bus.br_valid || pend) begin
              // drop the returned word; re-request at the redirect target
              pc     <= redir;
              addr_q <= redir;
              pend   <= 1'b0;
            end else begin
              inst_q <= bus.imem_rdata;
              ipc_q  <= pc;
              pc     <= pc_inc;
              addr_q <= pc_inc;
              req_q  <= 1'b0;
              ivld_q <= 1'b1;
              state  <= HOLD;
            end
          end else if (bus.br_valid) begin
            // address must stay stable until ack; defer the redirect
            pend     <= 1'b1;
            pend_tgt <= tgt;
          end
        end
        HOLD: begin
          if (trap) begin
            mis_q  <= 1'b1;
            ivld_q <= 1'b0;
            state  <= HALTED;
          end else if (bus.br_valid) begin
            pc     <= tgt;
            addr_q <= tgt;
            ivld_q <= 1'b0;
            if (bus.halt && bus.inst_ready) begin
              state <= HALTED;
            end else begin
              state <= REQ;
              req_q <= 1'b1;
            end
          end else if (bus.inst_ready) begin
            ivld_q <= 1'b0;
            if (bus.halt) begin
              state <= HALTED;
            end else begin
              state  <= REQ;
              req_q  <= 1'b1;
              addr_q <= pc;
            end
          end
        end
        HALTED: begin
          req_q  <= 1'b0;
          ivld_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = ivld_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.misalign   = TRAP_EN ? mis_q : 1'b0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (RESET_PC=0x100). A vector table
// covers sequential fetch, stalls, deferred/immediate redirects and PC
// wrap; hand sequences cover misalign, halt and mid-fetch reset.
module tb_pc_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.WIDTH(32)) bus ();

  pc_fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        brv;
    logic        brt;
    logic [31:0] brpc;
    logic [31:0] broff;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ivld;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_pc      = '0;
    bus.br_offset  = '0;
    bus.halt       = 1'b0;
  endtask

  task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                     input logic brv, input logic brt, input logic [31:0] brpc,
                     input logic [31:0] broff, input logic halt,
                     input logic e_req, input logic [31:0] e_addr, input logic e_ivld,
                     input logic [31:0] e_inst, input logic [31:0] e_ipc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.brv = brv; v.brt = brt;
    v.brpc = brpc; v.broff = broff; v.halt = halt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ivld = e_ivld;
    v.e_inst = e_inst; v.e_ipc = e_ipc;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    step();
    chk("rst_req",  {31'd0, bus.imem_req},   32'd0);
    chk("rst_addr", bus.imem_addr,            32'h100);
    chk("rst_ivld", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst,                 32'd0);
    chk("rst_ipc",  bus.inst_pc,              32'd0);
    chk("rst_mis",  {31'd0, bus.misalign},   32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    //  ack rdata         rdy brv brt brpc          broff         hlt | req addr          ivld inst          ipc
    add(0, 32'h0,         0,  0,  0,  32'h0,        32'h0,        0,    1, 32'h100,      0,   32'h0,        32'h0);
    add(1, 32'hA0,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h104,      1,   32'hA0,       32'h100);
    add(0, 32'h0,         1,  0,  0,  32'h0,        32'h0,        0,    1, 32'h104,      0,   32'h0,        32'h0);
    add(1, 32'hA1,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h108,      1,   32'hA1,       32'h104);
    add(0, 32'h0,         1,  0,  0,  32'h0,        32'h0,        0,    1, 32'h108,      0,   32'h0,        32'h0);
    add(1, 32'hA2,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h10C,      1,   32'hA2,       32'h108);
    add(0, 32'h0,         0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h10C,      1,   32'hA2,       32'h108);
    add(0, 32'h0,         1,  0,  0,  32'h0,        32'h0,        0,    1, 32'h10C,      0,   32'h0,        32'h0);
    // redirect while the fetch at 0x10C waits; halt outside HOLD ignored
    add(0, 32'h0,         0,  1,  1,  32'h3F0,      32'h10,       0,    1, 32'h10C,      0,   32'h0,        32'h0);
    add(0, 32'h0,         0,  0,  0,  32'h0,        32'h0,        1,    1, 32'h10C,      0,   32'h0,        32'h0);
    add(1, 32'hBAD0_BAD0, 0,  0,  0,  32'h0,        32'h0,        0,    1, 32'h400,      0,   32'h0,        32'h0);
    add(1, 32'hC0,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h404,      1,   32'hC0,       32'h400);
    // HOLD redirect with inst_ready high in the same cycle
    add(0, 32'h0,         1,  1,  1,  32'h400,      32'hFFFF_FE00,0,    1, 32'h200,      0,   32'h0,        32'h0);
    add(1, 32'hC1,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h204,      1,   32'hC1,       32'h200);
    add(0, 32'h0,         0,  1,  1,  32'h200,      32'hFFFF_FFF0,0,    1, 32'h1F0,      0,   32'h0,        32'h0);
    add(1, 32'hC2,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h1F4,      1,   32'hC2,       32'h1F0);
    // PC wrap
    add(0, 32'h0,         0,  1,  1,  32'h0,        32'hFFFF_FFFC,0,    1, 32'hFFFF_FFFC,0,   32'h0,        32'h0);
    add(1, 32'hD0,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h0,        1,   32'hD0,       32'hFFFF_FFFC);
    add(0, 32'h0,         1,  0,  0,  32'h0,        32'h0,        0,    1, 32'h0,        0,   32'h0,        32'h0);
    add(1, 32'hD1,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h4,        1,   32'hD1,       32'h0);
    add(0, 32'h0,         0,  1,  1,  32'hFFFF_FFF8,32'h10,       0,    1, 32'h8,        0,   32'h0,        32'h0);
    add(1, 32'hD2,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'hC,        1,   32'hD2,       32'h8);
    // not-taken redirect goes to br_pc+4
    add(0, 32'h0,         0,  1,  0,  32'h50,       32'h1234,     0,    1, 32'h54,       0,   32'h0,        32'h0);
    add(1, 32'hD3,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'h58,       1,   32'hD3,       32'h54);
    add(0, 32'h0,         1,  0,  0,  32'h0,        32'h0,        0,    1, 32'h58,       0,   32'h0,        32'h0);
    // redirect coinciding with ack: word dropped, target applied directly
    add(1, 32'hBAD1_BAD1, 0,  1,  1,  32'h80,       32'h20,       0,    1, 32'hA0,       0,   32'h0,        32'h0);
    add(1, 32'hE0,        0,  0,  0,  32'h0,        32'h0,        0,    0, 32'hA4,       1,   32'hE0,       32'hA0);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      bus.imem_ack   = vq[i].ack;
      bus.imem_rdata = vq[i].rdata;
      bus.inst_ready = vq[i].ready;
      bus.br_valid   = vq[i].brv;
      bus.br_taken   = vq[i].brt;
      bus.br_pc      = vq[i].brpc;
      bus.br_offset  = vq[i].broff;
      bus.halt       = vq[i].halt;
      step();
      chk($sformatf("v%0d_req", i),  {31'd0, bus.imem_req},   {31'd0, vq[i].e_req});
      chk($sformatf("v%0d_ivld", i), {31'd0, bus.inst_valid}, {31'd0, vq[i].e_ivld});
      if (vq[i].e_req) chk($sformatf("v%0d_addr", i), bus.imem_addr, vq[i].e_addr);
      if (vq[i].e_ivld) begin
        chk($sformatf("v%0d_inst", i), bus.inst,    vq[i].e_inst);
        chk($sformatf("v%0d_ipc", i),  bus.inst_pc, vq[i].e_ipc);
      end
    end

    // misaligned redirect target 0x202 from HOLD
    idle_in();
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.br_pc = 32'h200; bus.br_offset = 32'h2;
    step();
    idle_in();
`ifdef PCFETCH_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, bus.misalign},   32'd1);
    chk("mis_req",  {31'd0, bus.imem_req},   32'd0);
    chk("mis_ivld", {31'd0, bus.inst_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mis_noreq", {31'd0, bus.imem_req}, 32'd0);
    end
    chk("mis_sticky", {31'd0, bus.misalign}, 32'd1);
`else
    chk("mis_flag", {31'd0, bus.misalign}, 32'd0);
    chk("mis_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("mis_addr", bus.imem_addr,         32'h200);
`endif

    // halt at consume, stay halted, then restart by reset
    do_reset();
    step();
    chk("h_req0", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hF0;
    step();
    idle_in();
    chk("h_hold_ipc", bus.inst_pc, 32'h100);
    bus.inst_ready = 1'b1; bus.halt = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      chk("h_noreq",  {31'd0, bus.imem_req},   32'd0);
      chk("h_noivld", {31'd0, bus.inst_valid}, 32'd0);
      bus.imem_ack = 1'b1;
      bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_pc = 32'h300;
      step();
    end
    do_reset();
    step();
    chk("restart_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr,         32'h100);

    // reset while a fetch is outstanding drops the request next cycle
    step();
    chk("midrst_wait", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_restart", bus.imem_addr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
